ysyx_25040111_wbu: RTL

- Receiving end of the EXU "abt" handshake: accepts one retired-execute transaction at a time and performs the data-memory access for loads and stores.
- Aligns, extends and writes back load data to the GPR file; writes the CSR file.
- Pulses abt_finish/abt_frd so the EXU releases its read-after-write lock.
- Sits between the EXU and the register files / data bus; at most one transaction is outstanding.

---
 rtl/ysyx_25040111_wbu_pkg.sv | 20 ++
 rtl/ysyx_25040111_lsu_align.sv | 61 ++++++
 rtl/ysyx_25040111_wbu.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040111_wbu_pkg.sv
// Shared encodings for the write-back unit: access sizes, FSM states and bus width.
package ysyx_25040111_wbu_pkg;

    localparam int BUS_W = 32;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_B    = 2'b01,
        SZ_H    = 2'b10,
        SZ_W    = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        WB   = 2'b11
    } wbu_state_e;

endpackage

// File: rtl/ysyx_25040111_lsu_align.sv
// Combinational lane steering for the WBU: store replication/strobes, load shift/extension
// and the size-vs-address misalignment check.
module ysyx_25040111_lsu_align
    import ysyx_25040111_wbu_pkg::*;
(
    input  logic [1:0]       mask,
    input  logic [1:0]       addr_lo,
    input  logic             is_store,
    input  logic [BUS_W-1:0] st_data,
    output logic [BUS_W-1:0] lane_wdata,
    output logic [3:0]       lane_wstrb,
    input  logic [BUS_W-1:0] rdata,
    input  logic             rsign,
    output logic [BUS_W-1:0] ld_data,
    input  logic [1:0]       chk_mask,
    input  logic [1:0]       chk_addr_lo,
    output logic             misalign
);

    logic [BUS_W-1:0] shifted;

    always_comb begin
        lane_wdata = st_data;
        lane_wstrb = 4'hF;
        case (size_e'(mask))
            SZ_B: begin
                lane_wdata = {4{st_data[7:0]}};
                lane_wstrb = 4'b0001 << addr_lo;
            end
            SZ_H: begin
                lane_wdata = {2{st_data[15:0]}};
                lane_wstrb = 4'b0011 << addr_lo;
            end
            default: begin
                lane_wdata = st_data;
                lane_wstrb = 4'hF;
            end
        endcase
        // Loads never assert strobes; the bus returns the full word.
        if (!is_store) begin
            lane_wstrb = 4'h0;
        end
    end

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (size_e'(mask))
            SZ_B:    ld_data = rsign ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'h0, shifted[7:0]};
            SZ_H:    ld_data = rsign ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_comb begin
        misalign = ((size_e'(chk_mask) == SZ_H) && chk_addr_lo[0]) ||
                   ((size_e'(chk_mask) == SZ_W) && (chk_addr_lo != 2'b00));
    end

endmodule

// File: rtl/ysyx_25040111_wbu.sv
// Write-back unit: accepts one EXU transaction, performs its data-memory access if any,
// then writes GPR/CSR and pulses the retire/commit outputs for exactly one cycle.
module ysyx_25040111_wbu
    import ysyx_25040111_wbu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        abt_valid,
    output logic        abt_ready,
    input  logic        abt_men,
    input  logic [4:0]  abt_ard,
    input  logic [31:0] abt_rd,
    input  logic        abt_gen,
    input  logic [11:0] abt_acsr,
    input  logic [31:0] abt_csr,
    input  logic        abt_sen,
    input  logic        abt_write,
    input  logic [31:0] abt_wdata,
    input  logic [31:0] abt_addr,
    input  logic [1:0]  abt_mask,
    input  logic        abt_rsign,
    input  logic [31:0] abt_pc,
    output logic        abt_finish,
    output logic [4:0]  abt_frd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    input  logic        mem_rsp_err,
    output logic        gpr_wen,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        csr_wen,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic        exc_misalign,
    output logic        exc_buserr
);

    wbu_state_e state, state_n;

    logic        r_men, r_gen, r_sen, r_write, r_rsign;
    logic [4:0]  r_ard;
    logic [31:0] r_rd, r_csr, r_wdata, r_addr, r_pc, r_load;
    logic [11:0] r_acsr;
    logic [1:0]  r_mask;
    logic        f_misalign, f_buserr;
    logic [31:0] wait_cnt;

    logic [31:0] lane_wdata, ld_data;
    logic [3:0]  lane_wstrb;
    logic        in_misalign;
    logic        timeout_hit;

    ysyx_25040111_lsu_align u_align (
        .mask        (r_mask),
        .addr_lo     (r_addr[1:0]),
        .is_store    (r_write),
        .st_data     (r_wdata),
        .lane_wdata  (lane_wdata),
        .lane_wstrb  (lane_wstrb),
        .rdata       (mem_rsp_rdata),
        .rsign       (r_rsign),
        .ld_data     (ld_data),
        .chk_mask    (abt_mask),
        .chk_addr_lo (abt_addr[1:0]),
        .misalign    (in_misalign)
    );

    assign timeout_hit = (TIMEOUT_CYC != 0) && ((wait_cnt + 32'd1) == TIMEOUT_CYC);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        abt_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = 32'h0;
        mem_req_wdata = 32'h0;
        mem_req_wstrb = 4'h0;
        gpr_wen       = 1'b0;
        gpr_waddr     = 5'h0;
        gpr_wdata     = 32'h0;
        csr_wen       = 1'b0;
        csr_waddr     = 12'h0;
        csr_wdata     = 32'h0;
        abt_finish    = 1'b0;
        abt_frd       = 5'h0;
        commit_valid  = 1'b0;
        commit_pc     = 32'h0;
        exc_misalign  = 1'b0;
        exc_buserr    = 1'b0;
        case (state)
            IDLE: begin
                abt_ready = 1'b1;
                if (abt_valid) begin
                    state_n = (abt_men && !in_misalign) ? REQ : WB;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = r_write;
                mem_req_addr  = {r_addr[31:2], 2'b00};
                mem_req_wdata = lane_wdata;
                mem_req_wstrb = lane_wstrb;
                if (mem_req_ready) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid || timeout_hit) begin
                    state_n = WB;
                end
            end
            WB: begin
                state_n      = IDLE;
                gpr_wen      = r_gen && (r_ard != 5'd0);
                gpr_waddr    = r_ard;
                gpr_wdata    = (r_men && !r_write) ? r_load : r_rd;
                csr_wen      = r_sen;
                csr_waddr    = r_acsr;
                csr_wdata    = r_csr;
                abt_finish   = 1'b1;
                abt_frd      = r_ard;
                commit_valid = 1'b1;
                commit_pc    = r_pc;
                exc_misalign = f_misalign;
                exc_buserr   = f_buserr;
            end
            default: state_n = IDLE;
        endcase
    end

    // Transaction fields are latched once at acceptance; r_load starts at 0 so misaligned
    // or faulted loads retire a zero without a separate path.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_men      <= 1'b0;
            r_gen      <= 1'b0;
            r_sen      <= 1'b0;
            r_write    <= 1'b0;
            r_rsign    <= 1'b0;
            r_ard      <= 5'h0;
            r_rd       <= 32'h0;
            r_acsr     <= 12'h0;
            r_csr      <= 32'h0;
            r_wdata    <= 32'h0;
            r_addr     <= 32'h0;
            r_mask     <= 2'b00;
            r_pc       <= 32'h0;
            r_load     <= 32'h0;
            f_misalign <= 1'b0;
            f_buserr   <= 1'b0;
            wait_cnt   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (abt_valid) begin
                        r_men      <= abt_men;
                        r_gen      <= abt_gen;
                        r_sen      <= abt_sen;
                        r_write    <= abt_write;
                        r_rsign    <= abt_rsign;
                        r_ard      <= abt_ard;
                        r_rd       <= abt_rd;
                        r_acsr     <= abt_acsr;
                        r_csr      <= abt_csr;
                        r_wdata    <= abt_wdata;
                        r_addr     <= abt_addr;
                        r_mask     <= abt_mask;
                        r_pc       <= abt_pc;
                        r_load     <= 32'h0;
                        f_misalign <= abt_men && in_misalign;
                        f_buserr   <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        wait_cnt <= 32'h0;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        r_load   <= mem_rsp_err ? 32'h0 : ld_data;
                        f_buserr <= mem_rsp_err;
                    end else if (timeout_hit) begin
                        f_buserr <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
